ttt_turn_sequencer: RTL

//   Turn controller for the tic-tac-toe game. Owns the board's single write port.

---
 rtl/ttt_pkg.sv | 31 +++
 rtl/ttt_turn_sequencer_if.sv | 33 +++
 rtl/ttt_edge_det.sv | 19 +
 rtl/ttt_turn_sequencer.sv | 112 +++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn controller.
package ttt_pkg;

    localparam logic [1:0] P_NONE = 2'b00;
    localparam logic [1:0] P_ONE  = 2'b01;
    localparam logic [1:0] P_TWO  = 2'b10;

    localparam int NUM_CELLS = 9;

    typedef enum logic [2:0] {
        P1_TURN,
        P2_TURN,
        COMMIT,
        SETTLE,
        OVER
    } state_t;

    // True when pos names a real cell that is still empty.
    function automatic logic legal_cell(
        logic [NUM_CELLS-1:0] occ,
        logic [3:0]           pos
    );
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (pos == 4'(i) && !occ[i]) ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/ttt_turn_sequencer_if.sv
// Player inputs, board write port and game status of the turn controller.
interface ttt_turn_sequencer_if;
    import ttt_pkg::*;

    logic                 p1;
    logic                 p2;
    logic [3:0]           p1_pos;
    logic [3:0]           p2_pos;
    logic [NUM_CELLS-1:0] board_occ;
    logic [1:0]           winner;
    logic                 wr_en;
    logic [3:0]           wr_addr;
    logic [1:0]           wr_who;
    logic [1:0]           turn;
    logic                 illegal_move;
    logic                 timeout;
    logic [3:0]           move_cnt;
    logic                 game_over;
    logic                 draw;

    modport master (
        input  p1, p2, p1_pos, p2_pos, board_occ, winner,
        output wr_en, wr_addr, wr_who, turn, illegal_move,
        output timeout, move_cnt, game_over, draw
    );

    modport slave (
        output p1, p2, p1_pos, p2_pos, board_occ, winner,
        input  wr_en, wr_addr, wr_who, turn, illegal_move,
        input  timeout, move_cnt, game_over, draw
    );

endinterface

// File: rtl/ttt_edge_det.sv
// Rising-edge detector; prev resets high so a button held through reset
// does not register as a press.
module ttt_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!reset) prev <= 1'b1;
        else        prev <= d;
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/ttt_turn_sequencer.sv
// Turn controller: arbitrates the board write port between two players,
// enforces alternation, times out idle turns and declares win or draw.
module ttt_turn_sequencer
    import ttt_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000,
    parameter int TMR_W       = 16
) (
    input logic                    clk,
    input logic                    reset,
    ttt_turn_sequencer_if.master   bus
);

    state_t           state;
    logic [TMR_W-1:0] tmr;

    logic p1_rise, p2_rise;
    logic is_p2, act_rise, ina_rise, act_ok, to_hit;
    logic [3:0] act_pos;

    ttt_edge_det u_p1_edge (
        .clk   (clk),
        .reset (reset),
        .d     (bus.p1),
        .rise  (p1_rise)
    );

    ttt_edge_det u_p2_edge (
        .clk   (clk),
        .reset (reset),
        .d     (bus.p2),
        .rise  (p2_rise)
    );

    assign is_p2    = (state == P2_TURN);
    assign act_rise = is_p2 ? p2_rise : p1_rise;
    assign ina_rise = is_p2 ? p1_rise : p2_rise;
    assign act_pos  = is_p2 ? bus.p2_pos : bus.p1_pos;
    assign act_ok   = legal_cell(bus.board_occ, act_pos);
    assign to_hit   = (TIMEOUT_CYC != 0) &&
                      (tmr == TMR_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= P1_TURN;
            tmr              <= '0;
            bus.wr_en        <= 1'b0;
            bus.wr_addr      <= 4'd0;
            bus.wr_who       <= P_NONE;
            bus.turn         <= P_ONE;
            bus.illegal_move <= 1'b0;
            bus.timeout      <= 1'b0;
            bus.move_cnt     <= 4'd0;
            bus.game_over    <= 1'b0;
            bus.draw         <= 1'b0;
        end else begin
            bus.wr_en        <= 1'b0;
            bus.illegal_move <= 1'b0;
            bus.timeout      <= 1'b0;
            unique case (state)
                P1_TURN, P2_TURN: begin
                    if (act_rise && act_ok) begin
                        state            <= COMMIT;
                        tmr              <= '0;
                        bus.wr_en        <= 1'b1;
                        bus.wr_addr      <= act_pos;
                        bus.wr_who       <= is_p2 ? P_TWO : P_ONE;
                        bus.illegal_move <= ina_rise;
                        if (bus.move_cnt != 4'(NUM_CELLS))
                            bus.move_cnt <= bus.move_cnt + 4'd1;
                    end else begin
                        bus.illegal_move <= act_rise | ina_rise;
                        // an illegal attempt by the mover restarts their clock
                        if (act_rise) begin
                            tmr <= '0;
                        end else if (to_hit) begin
                            tmr         <= '0;
                            bus.timeout <= 1'b1;
                            state       <= is_p2 ? P1_TURN : P2_TURN;
                            bus.turn    <= is_p2 ? P_ONE : P_TWO;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                end
                COMMIT: state <= SETTLE;
                SETTLE: begin
                    tmr <= '0;
                    if (bus.winner != P_NONE) begin
                        state         <= OVER;
                        bus.turn      <= P_NONE;
                        bus.game_over <= 1'b1;
                    end else if (bus.move_cnt == 4'(NUM_CELLS)) begin
                        state         <= OVER;
                        bus.turn      <= P_NONE;
                        bus.game_over <= 1'b1;
                        bus.draw      <= 1'b1;
                    end else if (bus.wr_who == P_ONE) begin
                        state    <= P2_TURN;
                        bus.turn <= P_TWO;
                    end else begin
                        state    <= P1_TURN;
                        bus.turn <= P_ONE;
                    end
                end
                OVER: bus.illegal_move <= p1_rise | p2_rise;
                default: state <= P1_TURN;
            endcase
        end
    end

endmodule
